mutation_engine: RTL

MUTATION_ENGINE -- requirements
Module: mutation_engine

---
 rtl/mutation_engine.sv | 117 +++++++++++
 1 files changed

// File: rtl/mutation_engine.sv
// rtl/mutation_engine.sv - LFSR-driven bit-flip mutation stage with valid/ready handshake
// Optional MUTATION_ELITISM_EN: child 0 passes through unmutated while its LFSRs still step.
module mutation_engine #(
    parameter int          CHROM_WIDTH  = 8,
    parameter int          NUM_CHILDREN = 2,
    parameter logic [31:0] SEED_STRIDE  = 32'h1248_8421,
    localparam int         TOTAL        = NUM_CHILDREN * CHROM_WIDTH,
    localparam int         CNT_W        = $clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      seed,
    input  logic             seed_load,
    input  logic [7:0]       mut_rate,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOTAL-1:0] orig_children,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOTAL-1:0] mut_children,
    output logic [CNT_W-1:0] mut_count
);

    localparam int          K    = TOTAL / 4;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q [K];
    logic [31:0]        lfsr_d [K];
    logic               out_valid_q, out_valid_d;
    logic [TOTAL-1:0]   mut_children_q, mut_children_d;
    logic [CNT_W-1:0]   mut_count_q, mut_count_d;
    logic [TOTAL-1:0]   flip_mask;
    logic [CNT_W-1:0]   flip_count;
    logic               accept;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] seed_for(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base + 32'(k) * SEED_STRIDE;
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
    endfunction

    assign in_ready     = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign mut_children = mut_children_q;
    assign mut_count    = mut_count_q;

    // Flat bit i takes byte (i%4) of LFSR i/4 as its random byte.
    always_comb begin
        flip_mask  = '0;
        flip_count = '0;
        for (int i = 0; i < TOTAL; i++) begin
            flip_mask[i] = lfsr_q[i/4][8*(i%4) +: 8] < mut_rate;
        end
`ifdef MUTATION_ELITISM_EN
        flip_mask[CHROM_WIDTH-1:0] = '0;
`endif
        for (int i = 0; i < TOTAL; i++) begin
            flip_count = flip_count + CNT_W'(flip_mask[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        out_valid_d    = out_valid_q;
        mut_children_d = mut_children_q;
        mut_count_d    = mut_count_q;
        case (state_q)
            INIT: begin
                for (int k = 0; k < K; k++) lfsr_d[k] = seed_for(seed, k);
                state_d = RUN;
            end
            RUN: begin
                if (seed_load) begin
                    for (int k = 0; k < K; k++) lfsr_d[k] = seed_for(seed, k);
                end else if (accept) begin
                    for (int k = 0; k < K; k++) lfsr_d[k] = lfsr_step(lfsr_q[k]);
                end
            end
            default: state_d = INIT;
        endcase
        // Accept wins over drain so a simultaneous handshake loads with no bubble.
        if (accept) begin
            mut_children_d = orig_children ^ flip_mask;
            mut_count_d    = flip_count;
            out_valid_d    = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= INIT;
            out_valid_q    <= 1'b0;
            mut_children_q <= '0;
            mut_count_q    <= '0;
            for (int k = 0; k < K; k++) lfsr_q[k] <= 32'h0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            mut_children_q <= mut_children_d;
            mut_count_q    <= mut_count_d;
            for (int k = 0; k < K; k++) lfsr_q[k] <= lfsr_d[k];
        end
    end

endmodule
